// File: rtl/next_address_stack.sv
// Next-address unit for the hotstate microsequencer: selects the next control-word address
// from halt, switch dispatch, interrupts, jump/call, return/reti or sequential increment.
// Every output is registered; one cycle from inputs to nextadr. No backpressure; ready=0 acts as reset.
module next_address_stack #(
  parameter int ADDR_WIDTH  = 8,
  parameter int STACK_DEPTH = 4,
  parameter int NUM_IRQ     = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_ready,
  input  logic                            i_hlt,
  input  logic [ADDR_WIDTH-1:0]           i_address,
  input  logic [ADDR_WIDTH-1:0]           i_jmpadr,
  input  logic                            i_jadr,
  input  logic                            i_call,
  input  logic                            i_ret,
  input  logic                            i_reti,
  input  logic                            i_switch_active,
  input  logic [ADDR_WIDTH-1:0]           i_switch_adr,
  input  logic                            i_irq_en,
  input  logic [NUM_IRQ-1:0]              i_irq_req,
  input  logic [NUM_IRQ*ADDR_WIDTH-1:0]   i_irq_vec,
  output logic [ADDR_WIDTH-1:0]           o_nextadr,
  output logic [NUM_IRQ-1:0]              o_irq_ack,
  output logic                            o_in_isr,
  output logic [$clog2(STACK_DEPTH+1)-1:0] o_depth,
  output logic                            o_overflow,
  output logic                            o_underflow
);

  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_WIDTH-1:0] r_nextadr;
  logic [ADDR_WIDTH-1:0] r_stack [STACK_DEPTH];
  logic [DW-1:0]         r_depth;
  logic [NUM_IRQ-1:0]    r_pending;
  logic [NUM_IRQ-1:0]    r_irq_ack;
  logic                  r_in_isr;
  logic                  r_overflow;
  logic                  r_underflow;

  logic [ADDR_WIDTH-1:0] w_seq;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_take;
  logic [IW-1:0]         w_push_idx;
  logic [IW-1:0]         w_pop_idx;
  logic [NUM_IRQ-1:0]    w_win_oh;
  logic [ADDR_WIDTH-1:0] w_win_vec;
  logic [ADDR_WIDTH-1:0] w_nxt_adr;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_isr_nxt;
  logic [NUM_IRQ-1:0]    w_ack_nxt;
  logic [NUM_IRQ-1:0]    w_clr;
  logic                  w_ovf_set;
  logic                  w_udf_set;

  assign w_seq      = i_address + ADDR_WIDTH'(1);
  assign w_full     = (r_depth == DW'(STACK_DEPTH));
  assign w_empty    = (r_depth == '0);
  assign w_push_idx = IW'(r_depth);
  assign w_pop_idx  = IW'(r_depth - DW'(1));

  // Any explicit control strobe suppresses interrupt entry; halt is handled by priority below.
  assign w_take = i_irq_en & ~r_in_isr & (|r_pending) & ~w_full &
                  ~i_jadr & ~i_ret & ~i_reti & ~i_switch_active;

  // Lowest-index pending channel wins: scan downward so the last hit is the lowest index.
  always_comb begin
    w_win_oh  = '0;
    w_win_vec = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (r_pending[i]) begin
        w_win_oh    = '0;
        w_win_oh[i] = 1'b1;
        w_win_vec   = i_irq_vec[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  // Priority selection of next address and the stack/interrupt side effects it implies.
  always_comb begin
    w_nxt_adr = w_seq;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_isr_nxt = r_in_isr;
    w_ack_nxt = '0;
    w_clr     = '0;
    w_ovf_set = 1'b0;
    w_udf_set = 1'b0;
    if (i_hlt) begin
      w_nxt_adr = i_address;
    end else if (i_switch_active) begin
      w_nxt_adr = i_switch_adr;
    end else if (w_take) begin
      w_push    = 1'b1;
      w_nxt_adr = w_win_vec;
      w_isr_nxt = 1'b1;
      w_clr     = w_win_oh;
      w_ack_nxt = w_win_oh;
    end else if (i_jadr) begin
      w_nxt_adr = i_jmpadr;
      if (i_call) begin
        if (!w_full) w_push = 1'b1;
        else         w_ovf_set = 1'b1;
      end
    end else if (i_reti || i_ret) begin
      if (i_reti) w_isr_nxt = 1'b0;
      if (!w_empty) begin
        w_pop     = 1'b1;
        w_nxt_adr = r_stack[w_pop_idx];
      end else begin
        w_udf_set = 1'b1;
      end
    end
  end

  // Register state; rst and ready=0 both clear everything except stack contents.
  always_ff @(posedge clk) begin
    if (rst || !i_ready) begin
      r_nextadr   <= '0;
      r_depth     <= '0;
      r_pending   <= '0;
      r_in_isr    <= 1'b0;
      r_irq_ack   <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_nextadr   <= w_nxt_adr;
      r_pending   <= (r_pending | i_irq_req) & ~w_clr;
      r_in_isr    <= w_isr_nxt;
      r_irq_ack   <= w_ack_nxt;
      r_overflow  <= r_overflow | w_ovf_set;
      r_underflow <= r_underflow | w_udf_set;
      if (w_push) begin
        r_stack[w_push_idx] <= w_seq;
        r_depth             <= r_depth + DW'(1);
      end else if (w_pop) begin
        r_depth <= r_depth - DW'(1);
      end
    end
  end

  assign o_nextadr   = r_nextadr;
  assign o_irq_ack   = r_irq_ack;
  assign o_in_isr    = r_in_isr;
  assign o_depth     = r_depth;
  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;

endmodule

// File: tb/tb_next_address_stack.sv
// Self-checking bench for next_address_stack: directed scenarios plus randomized
// traffic compared cycle by cycle against a queue-based reference model.
// Inputs change 1ns after the rising edge; outputs are sampled at that same point.
module tb_next_address_stack;

  localparam int AW = 8;
  localparam int SD = 4;
  localparam int NI = 4;

  logic          clk = 1'b0;
  logic          rst, ready, hlt, jadr, call, ret, reti, sw, irq_en;
  logic [AW-1:0] address, jmpadr, sw_adr;
  logic [NI-1:0] irq_req;
  logic [NI*AW-1:0] irq_vec;
  logic [AW-1:0] nextadr;
  logic [NI-1:0] irq_ack;
  logic          in_isr, overflow, underflow;
  logic [2:0]    depth;

  logic [AW-1:0] vec [NI];

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [AW-1:0] m_nextadr;
  logic [AW-1:0] m_stack [$];
  logic [NI-1:0] m_pend;
  logic [NI-1:0] m_ack;
  logic          m_isr, m_ovf, m_udf;

  always #5 clk = ~clk;

  next_address_stack #(.ADDR_WIDTH(AW), .STACK_DEPTH(SD), .NUM_IRQ(NI)) dut (
    .clk(clk), .rst(rst), .i_ready(ready), .i_hlt(hlt), .i_address(address),
    .i_jmpadr(jmpadr), .i_jadr(jadr), .i_call(call), .i_ret(ret), .i_reti(reti),
    .i_switch_active(sw), .i_switch_adr(sw_adr), .i_irq_en(irq_en),
    .i_irq_req(irq_req), .i_irq_vec(irq_vec), .o_nextadr(nextadr),
    .o_irq_ack(irq_ack), .o_in_isr(in_isr), .o_depth(depth),
    .o_overflow(overflow), .o_underflow(underflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle();
    rst = 0; ready = 1; hlt = 0; jadr = 0; call = 0; ret = 0; reti = 0; sw = 0;
    irq_req = '0; jmpadr = '0; sw_adr = '0;
  endtask

  task automatic pack_vec();
    for (int i = 0; i < NI; i++) irq_vec[i*AW +: AW] = vec[i];
  endtask

  // Apply the rules of the next-address unit to the current inputs.
  task automatic model_step();
    logic [AW-1:0] seq;
    logic [NI-1:0] new_pend;
    logic          take;
    int            w;
    if (rst || !ready) begin
      m_nextadr = '0; m_pend = '0; m_ack = '0; m_isr = 0; m_ovf = 0; m_udf = 0;
      m_stack.delete();
      return;
    end
    seq      = address + 8'd1;
    new_pend = m_pend | irq_req;
    m_ack    = '0;
    take = irq_en && !m_isr && (m_pend != 0) && (m_stack.size() < SD) &&
           !jadr && !ret && !reti && !sw;
    if (hlt) m_nextadr = address;
    else if (sw) m_nextadr = sw_adr;
    else if (take) begin
      w = 0;
      while (!m_pend[w]) w++;
      m_stack.push_back(seq);
      m_nextadr   = vec[w];
      m_isr       = 1;
      new_pend[w] = 1'b0;
      m_ack[w]    = 1'b1;
    end else if (jadr && call) begin
      if (m_stack.size() < SD) m_stack.push_back(seq);
      else m_ovf = 1;
      m_nextadr = jmpadr;
    end else if (jadr) m_nextadr = jmpadr;
    else if (reti || ret) begin
      if (reti) m_isr = 0;
      if (m_stack.size() > 0) m_nextadr = m_stack.pop_back();
      else begin m_udf = 1; m_nextadr = seq; end
    end else m_nextadr = seq;
    m_pend = new_pend;
  endtask

  task automatic cycle();
    pack_vec();
    model_step();
    @(posedge clk);
    #1;
    chk("nextadr",   32'(nextadr),   32'(m_nextadr));
    chk("irq_ack",   32'(irq_ack),   32'(m_ack));
    chk("in_isr",    32'(in_isr),    32'(m_isr));
    chk("depth",     32'(depth),     32'(m_stack.size()));
    chk("overflow",  32'(overflow),  32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_udf));
  endtask

  initial begin
    idle();
    irq_en = 0; address = '0;
    vec[0] = 8'h08; vec[1] = 8'h40; vec[2] = 8'h50; vec[3] = 8'h60;

    // reset and sequential run, including wrap
    rst = 1; cycle(); cycle();
    chk("rst_nextadr", 32'(nextadr), 32'h00);
    chk("rst_depth", 32'(depth), 32'h0);
    rst = 0; address = 8'h10; cycle(); chk("seq_10", 32'(nextadr), 32'h11);
    address = 8'h11; cycle(); chk("seq_11", 32'(nextadr), 32'h12);
    address = 8'hFF; cycle(); chk("seq_wrap", 32'(nextadr), 32'h00);

    // call and return
    address = 8'h20; jadr = 1; call = 1; jmpadr = 8'h80; cycle();
    chk("call_adr", 32'(nextadr), 32'h80); chk("call_depth", 32'(depth), 32'd1);
    idle(); address = 8'h80; ret = 1; cycle();
    chk("ret_adr", 32'(nextadr), 32'h21); chk("ret_depth", 32'(depth), 32'd0);

    // stack limits
    for (int i = 0; i < 5; i++) begin
      idle(); address = 8'(i); jadr = 1; call = 1; jmpadr = 8'(8'h90 + i); cycle();
    end
    chk("full_depth", 32'(depth), 32'd4);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_jump", 32'(nextadr), 32'h94);
    for (int i = 0; i < 5; i++) begin
      idle(); address = 8'hA0; ret = 1; cycle();
      if (i == 0) chk("pop_top", 32'(nextadr), 32'h04);
      if (i == 3) chk("pop_empty_depth", 32'(depth), 32'd0);
    end
    chk("udf_set", 32'(underflow), 32'd1);
    chk("udf_seq", 32'(nextadr), 32'hA1);
    idle(); ready = 0; cycle();
    chk("ready_clr_ovf", 32'(overflow), 32'd0);

    // interrupt priority: pulse 1010, ch1 first, ch3 after reti
    idle(); irq_en = 1; address = 8'h30; irq_req = 4'b1010; cycle();
    chk("irq_latch_seq", 32'(nextadr), 32'h31);
    irq_req = '0; cycle();
    chk("irq_ch1_adr", 32'(nextadr), 32'h40);
    chk("irq_ch1_ack", 32'(irq_ack), 32'b0010);
    chk("irq_ch1_isr", 32'(in_isr), 32'd1);
    address = 8'h40; reti = 1; cycle();
    chk("reti_adr", 32'(nextadr), 32'h31); chk("reti_isr", 32'(in_isr), 32'd0);
    idle(); address = 8'h31; cycle();
    chk("irq_ch3_adr", 32'(nextadr), 32'h60); chk("irq_ch3_ack", 32'(irq_ack), 32'b1000);
    address = 8'h60; reti = 1; cycle();

    // blocking by jadr, hlt, switch, irq_en=0
    idle(); address = 8'h50; jadr = 1; jmpadr = 8'h70; irq_req = 4'b0001; cycle();
    chk("blk_jadr", 32'(nextadr), 32'h70);
    idle(); address = 8'h70; hlt = 1; cycle();
    chk("blk_hlt", 32'(nextadr), 32'h70);
    idle(); sw = 1; sw_adr = 8'h77; cycle();
    chk("blk_sw", 32'(nextadr), 32'h77);
    idle(); irq_en = 0; address = 8'h77; cycle();
    chk("blk_en", 32'(nextadr), 32'h78);
    irq_en = 1; address = 8'h78; cycle();
    chk("unblk_adr", 32'(nextadr), 32'h08); chk("unblk_ack", 32'(irq_ack), 32'b0001);
    address = 8'h08; reti = 1; cycle();

    // reset mid-ISR with a pending channel left over
    idle(); address = 8'h10; jadr = 1; call = 1; jmpadr = 8'h20; cycle();
    idle(); address = 8'h20; irq_req = 4'b0101; cycle();
    idle(); address = 8'h21; cycle();
    chk("mid_isr", 32'(in_isr), 32'd1); chk("mid_depth", 32'(depth), 32'd2);
    ready = 0; cycle();
    chk("mid_clr_isr", 32'(in_isr), 32'd0); chk("mid_clr_depth", 32'(depth), 32'd0);
    ready = 1;
    for (int i = 0; i < 5; i++) begin address = 8'(8'h40 + i); cycle(); end
    chk("no_stale_irq", 32'(in_isr), 32'd0);
    chk("no_stale_adr", 32'(nextadr), 32'h45);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst     = ($urandom_range(0, 199) == 0);
      ready   = ($urandom_range(0, 149) != 0);
      hlt     = ($urandom_range(0, 9) == 0);
      jadr    = ($urandom_range(0, 5) == 0);
      call    = $urandom_range(0, 1) == 1;
      ret     = ($urandom_range(0, 5) == 0);
      reti    = ($urandom_range(0, 7) == 0);
      sw      = ($urandom_range(0, 11) == 0);
      irq_en  = ($urandom_range(0, 3) != 0);
      irq_req = ($urandom_range(0, 4) == 0) ? NI'($urandom) : '0;
      address = AW'($urandom);
      jmpadr  = AW'($urandom);
      sw_adr  = AW'($urandom);
      if ($urandom_range(0, 49) == 0) vec[$urandom_range(0, NI-1)] = AW'($urandom);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/next_address_stack.md
# next_address_stack

Parametrised next-address unit for the hotstate microsequencer. Each cycle it registers the address of the next control word. It selects between switch dispatch, prioritised multi-channel interrupts, jump, subroutine call/return through an internal return-address stack, interrupt return, halt, and sequential increment. It sits between the control-word decoder (which supplies `address`, `jmpadr` and the control strobes) and the control-word memory (which is read at `nextadr`).

## Interface
Parameters:
- `ADDR_WIDTH`, 8, width of every address bus.
- `STACK_DEPTH`, 4, number of return-address stack entries (≥2).
- `NUM_IRQ`, 4, number of interrupt channels (≥1).

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `ready`  in  1  0 = soft reset; same effect as `rst`.
- `hlt`  in  1  hold the current address.
- `address`  in  ADDR_WIDTH  address of the control word currently executing.
- `jmpadr`  in  ADDR_WIDTH  jump/call target.
- `jadr`  in  1  jump strobe.
- `call`  in  1  qualifies `jadr` as a subroutine call.
- `ret`  in  1  subroutine return.
- `reti`  in  1  interrupt return.
- `switch_active`  in  1  switch dispatch strobe.
- `switch_adr`  in  ADDR_WIDTH  switch target.
- `irq_en`  in  1  global interrupt enable.
- `irq_req`  in  NUM_IRQ  level interrupt requests.
- `irq_vec`  in  NUM_IRQ*ADDR_WIDTH  vectors; channel i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- `nextadr`  out  ADDR_WIDTH  registered next address.
- `irq_ack`  out  NUM_IRQ  one-hot, one-cycle acknowledge of the taken channel.
- `in_isr`  out  1  an interrupt service routine is active.
- `depth`  out  $clog2(STACK_DEPTH+1)  current stack occupancy.
- `overflow`  out  1  sticky: a push was attempted while the stack was full.
- `underflow`  out  1  sticky: a pop was attempted while the stack was empty.

## Operation
- `rst`=1 or `ready`=0 gives the following state: `nextadr`=0, `depth`=0, pending=0, `in_isr`=0, `irq_ack`=0, `overflow`=0, `underflow`=0. Stack contents are don't-care.
- Pending latch: `pending |= irq_req` every non-reset cycle, including while halted. A channel's pending bit clears only when that channel is taken.
- `seq` = `address`+1, modulo 2^ADDR_WIDTH (0xFF+1 = 0x00 at width 8).
- `take` = `irq_en` & !`in_isr` & |pending & (`depth` < `STACK_DEPTH`) & !`jadr` & !`ret` & !`reti` & !`switch_active`.
- The winning channel is the lowest-index pending bit.
- Priority, evaluated when not in reset, is listed below from highest to lowest; the first matching row applies:
  1. `hlt`: `nextadr`=`address`. No stack, `in_isr` or `irq_ack` change.
  2. `switch_active`: `nextadr`=`switch_adr`.
  3. `take`: push `seq`; `nextadr`=vector[winner]; `in_isr`=1; clear pending[winner]; `irq_ack`[winner]=1 for the next cycle only.
  4. `jadr`&`call`: if not full, push `seq`; otherwise set `overflow` and skip the push. `nextadr`=`jmpadr` in both cases.
  5. `jadr`: `nextadr`=`jmpadr`.
  6. `reti`: pop into `nextadr`; `in_isr`=0.
  7. `ret`: pop into `nextadr`.
  8. Otherwise: `nextadr`=`seq`.
- Pop on an empty stack (rows 6 and 7): set `underflow`, `nextadr`=`seq`, `depth` stays 0. For `reti`, `in_isr` still clears.
- Nested interrupts are not supported. Calls inside an ISR use the same stack.
- `overflow` and `underflow` clear only on `rst` or `ready`=0.

## Timing
- Every output is a register, with one-cycle latency from the inputs to `nextadr`.
- A push and its `depth` increment become visible together on the edge after the request. A `ret` in the following cycle pops that value.
- `irq_ack` is high only in the cycle in which `nextadr` first equals the vector.
- A request that goes low after being latched is still serviced.
- Requests that arrive while `in_isr`=1, while the stack is full, or while `irq_en`=0 stay pending until `take` becomes true.
- When several strobes coincide, the priority list decides. A suppressed strobe has no side effects: no push, no pop, no pending clear.

## Test plan
- Reset and sequential run: hold `rst`, then release with `address` stepping 0x10, 0x11. Required: `nextadr` 0x00 during reset, then 0x11, 0x12. With `address`=0xFF, `nextadr`=0x00.
- Call and return: `address`=0x20, `jadr`=`call`=1, `jmpadr`=0x80 gives `nextadr`=0x80, `depth`=1. Then `ret` gives `nextadr`=0x21, `depth`=0.
- Stack limits (depth 4): five nested calls give `depth`=4 and `overflow`=1, and the fifth call still jumps to its `jmpadr`. Then five `ret`s: the fourth empties the stack and the fifth gives `underflow`=1 with `nextadr`=`address`+1.
- Interrupt priority: pulse `irq_req`=0b1010 for one cycle with vectors ch1=0x40 and ch3=0x60, `address`=0x30. Required: `nextadr`=0x40, `irq_ack`=0b0010, `in_isr`=1. After `reti`: `nextadr`=0x31. On the next sequential cycle, ch3 is taken and `nextadr`=0x60.
- Blocking: an `irq_req` that coincides with `jadr`, `hlt` or `switch_active`, or that arrives while `irq_en`=0, is not taken and stays pending. It is taken on the first clean sequential cycle.
- Reset mid-ISR: with `in_isr`=1, `depth`=2 and pending=0b0100, pulse `ready`=0. Required: all state clears and no later interrupt fires unless a new request arrives.
